// File: rtl/ov_cls_pkg.sv
// Shared definitions for the OV7670 capture/classify slice: treasure codes,
// capture FSM states and RGB332 overlay colours.
package ov_cls_pkg;

    localparam logic [2:0] TR_NONE    = 3'b000;
    localparam logic [2:0] TR_BLU_TRI = 3'b010;
    localparam logic [2:0] TR_RED_TRI = 3'b011;
    localparam logic [2:0] TR_BLU_DIA = 3'b100;
    localparam logic [2:0] TR_RED_DIA = 3'b101;
    localparam logic [2:0] TR_BLU_SQR = 3'b110;
    localparam logic [2:0] TR_RED_SQR = 3'b111;

    typedef enum logic [1:0] {
        SYNC,
        ACTIVE,
        CLASSIFY
    } cap_state_t;

    localparam logic [7:0] OV_GREEN = 8'b00011100;
    localparam logic [7:0] OV_BLUE  = 8'b00000011;
    localparam logic [7:0] OV_RED   = 8'b11100000;
    localparam logic [7:0] OV_WHITE = 8'b11111111;

endpackage

// File: rtl/ov_shape_decide.sv
// Combinational treasure decision from per-band left-edge sums and colour
// counts; the caller registers the code when the frame ends.
module ov_shape_decide
    import ov_cls_pkg::*;
#(
    parameter int unsigned N_BANDS  = 4,
    parameter int unsigned SUM_W    = 20,
    parameter int unsigned AREA_MIN = 1200
) (
    input  logic [N_BANDS-1:0][SUM_W-1:0] band_sum,
    input  logic [SUM_W-1:0]              blue_cnt,
    input  logic [SUM_W-1:0]              red_cnt,
    output logic [2:0]                    code
);

    localparam int unsigned TW = SUM_W + $clog2(N_BANDS);

    logic [TW-1:0]  upper;
    logic [TW-1:0]  lower;
    logic [TW-1:0]  total;
    logic [SUM_W:0] outer;
    logic [SUM_W:0] inner;
    logic           is_blue;

    always_comb begin
        upper = '0;
        lower = '0;
        for (int unsigned b = 0; b < N_BANDS; b++) begin
            if (b < N_BANDS / 2) upper = upper + TW'(band_sum[b]);
            else                 lower = lower + TW'(band_sum[b]);
        end
        total   = upper + lower;
        outer   = {1'b0, band_sum[0]} + {1'b0, band_sum[N_BANDS-1]};
        inner   = {1'b0, band_sum[N_BANDS/2-1]} + {1'b0, band_sum[N_BANDS/2]};
        is_blue = blue_cnt > red_cnt;

        if (total <= TW'(AREA_MIN))  code = TR_NONE;
        else if (upper > lower)      code = is_blue ? TR_BLU_TRI : TR_RED_TRI;
        else if (outer < inner)      code = is_blue ? TR_BLU_DIA : TR_RED_DIA;
        else                         code = is_blue ? TR_BLU_SQR : TR_RED_SQR;
    end

endmodule

// File: rtl/ov_capture_classifier.sv
// OV7670 RGB444 capture to RGB332 frame-buffer writes plus per-frame treasure
// classification. Define OVERLAY_EN to replace pixels with a hit-debug overlay.
module ov_capture_classifier
    import ov_cls_pkg::*;
#(
    parameter int unsigned WIDTH    = 176,
    parameter int unsigned HEIGHT   = 144,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned N_BANDS  = 4,
    parameter int unsigned ROI_X0   = 21,
    parameter int unsigned ROI_X1   = 154,
    parameter int unsigned ROI_Y0   = 39,
    parameter int unsigned BAND_H   = 24,
    parameter int unsigned CMIN     = 1,
    parameter int unsigned CMAX     = 6,
    parameter int unsigned AREA_MIN = 1200,
    parameter int unsigned SUM_W    = 20
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        D,
    output logic [7:0]        PIXEL_OUT,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic [2:0]        RESULT,
    output logic              RESULT_VALID,
    output logic              FRAME_ACTIVE
);

    localparam int unsigned XW       = $clog2(WIDTH + 1);
    localparam int unsigned YW       = $clog2(HEIGHT + 1);
    localparam int unsigned ROI_Y1   = ROI_Y0 + N_BANDS * BAND_H - 1;
    localparam logic [XW-1:0] X_SAT  = XW'(WIDTH);
    localparam logic [YW-1:0] Y_SAT  = YW'(HEIGHT);
    localparam logic [3:0]    CMIN_C = 4'(CMIN);
    localparam logic [3:0]    CMAX_C = 4'(CMAX);
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    cap_state_t state_q, state_d;

    logic                         prev_href, prev_vsync, phase, seen;
    logic [XW-1:0]                x;
    logic [YW-1:0]                y;
    logic [3:0]                   b_q;
    logic [N_BANDS-1:0][SUM_W-1:0] band_sum;
    logic [SUM_W-1:0]             blue_cnt, red_cnt;
    logic [2:0]                   code;

    logic                         vs_fall, vs_rise, href_fall;
    logic [3:0]                   pr, pg;
    logic                         in_roi, c_blue, c_red, hit, blue_hit, red_hit, write_ok;
    logic [N_BANDS-1:0]           band_sel;
    logic [7:0]                   pixel_d;
    logic [ADDR_W-1:0]            addr_d;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? SUM_MAX : s[SUM_W-1:0];
    endfunction

    always_comb begin
        vs_fall   = prev_vsync & ~VSYNC;
        vs_rise   = ~prev_vsync & VSYNC;
        href_fall = prev_href & ~HREF;
        pr        = D[3:0];
        pg        = D[7:4];
        in_roi    = (32'(x) >= ROI_X0) && (32'(x) <= ROI_X1) &&
                    (32'(y) >= ROI_Y0) && (32'(y) <= ROI_Y1);
        c_blue    = (b_q >= CMIN_C) && (pr < CMAX_C) && (pg < CMAX_C);
        c_red     = (pr >= CMIN_C) && (pg < CMAX_C) && (b_q < CMAX_C);
        blue_hit  = in_roi && c_blue;
        red_hit   = in_roi && !c_blue && c_red;
        hit       = blue_hit || red_hit;
        write_ok  = (x < X_SAT) && (y < Y_SAT);
        addr_d    = ADDR_W'(32'(y) * WIDTH + 32'(x));
        band_sel  = '0;
        for (int unsigned b = 0; b < N_BANDS; b++) begin
            band_sel[b] = (32'(y) >= ROI_Y0 + b * BAND_H) &&
                          (32'(y) <  ROI_Y0 + (b + 1) * BAND_H);
        end
`ifdef OVERLAY_EN
        if (hit && !seen)  pixel_d = OV_GREEN;
        else if (blue_hit) pixel_d = OV_BLUE;
        else if (red_hit)  pixel_d = OV_RED;
        else               pixel_d = OV_WHITE;
`else
        pixel_d = {pr[3:1], pg[3:1], b_q[3:2]};
`endif
    end

    ov_shape_decide #(
        .N_BANDS  (N_BANDS),
        .SUM_W    (SUM_W),
        .AREA_MIN (AREA_MIN)
    ) u_decide (
        .band_sum (band_sum),
        .blue_cnt (blue_cnt),
        .red_cnt  (red_cnt),
        .code     (code)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= SYNC;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:     if (vs_fall) state_d = ACTIVE;
            ACTIVE:   if (vs_rise) state_d = CLASSIFY;
            CLASSIFY: state_d = SYNC;
            default:  state_d = SYNC;
        endcase
    end

    assign FRAME_ACTIVE = (state_q == ACTIVE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_href    <= 1'b0;
            prev_vsync   <= 1'b0;
            phase        <= 1'b0;
            seen         <= 1'b0;
            x            <= '0;
            y            <= '0;
            b_q          <= '0;
            band_sum     <= '0;
            blue_cnt     <= '0;
            red_cnt      <= '0;
            PIXEL_OUT    <= '0;
            W_ADDR       <= '0;
            W_EN         <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
        end else begin
            prev_href    <= HREF;
            prev_vsync   <= VSYNC;
            W_EN         <= 1'b0;
            RESULT_VALID <= 1'b0;
            case (state_q)
                SYNC: begin
                    if (vs_fall) begin
                        x        <= '0;
                        y        <= '0;
                        phase    <= 1'b0;
                        seen     <= 1'b0;
                        band_sum <= '0;
                        blue_cnt <= '0;
                        red_cnt  <= '0;
                    end
                end
                ACTIVE: begin
                    // frame end wins over line end and over a half-received pixel
                    if (vs_rise) begin
                        phase <= 1'b0;
                    end else if (href_fall) begin
                        x     <= '0;
                        y     <= (y == Y_SAT) ? y : y + 1'b1;
                        phase <= 1'b0;
                        seen  <= 1'b0;
                    end else if (HREF) begin
                        if (!phase) begin
                            b_q   <= D[3:0];
                            phase <= 1'b1;
                        end else begin
                            phase     <= 1'b0;
                            PIXEL_OUT <= pixel_d;
                            W_ADDR    <= addr_d;
                            W_EN      <= write_ok;
                            if (x != X_SAT) x <= x + 1'b1;
                            if (hit && !seen) begin
                                seen <= 1'b1;
                                for (int unsigned b = 0; b < N_BANDS; b++) begin
                                    if (band_sel[b]) band_sum[b] <= sat_add(band_sum[b], SUM_W'(x));
                                end
                            end
                            if (blue_hit && blue_cnt != SUM_MAX) blue_cnt <= blue_cnt + 1'b1;
                            if (red_hit && red_cnt != SUM_MAX)   red_cnt  <= red_cnt + 1'b1;
                        end
                    end
                end
                CLASSIFY: begin
                    RESULT       <= code;
                    RESULT_VALID <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
